eeprom_access_arbiter: RTL and testbench
========================================

Name: eeprom_access_arbiter

Overview:
- Shares the single EEPROM byte port (`avs_s0_*` of the I2C EEPROM controller) among NUM_REQ Avalon-MM byte requesters, e.g. the settings loader, the host bridge and the diagnostics block.
- Grants round-robin and holds the grant for the whole I2C transaction.
- Registers and holds address and data stable for the full downstream transfer.
- Converts the downstream "waitrequest rises one cycle after the command" behaviour into a clean per-requester Avalon completion.
- Adds a busy timeout so a hung bus cannot stall requesters forever.

Parameters:
- NUM_REQ, 3, number of requester ports (1..8).
- TIMEOUT_CYCLES, 2_000_000, max csi_clk cycles from command issue to downstream completion.
- ACCEPT_CYCLES, 4, max cycles waiting for downstream waitrequest to rise after issue.

Ports:
- csi_clk  in  1  clock.
- rsi_reset  in  1  asynchronous, active-high reset.
- avs_req_read  in  NUM_REQ  per-requester read strobe; held until its waitrequest is low.
- avs_req_write  in  NUM_REQ  per-requester write strobe.
- avs_req_address  in  NUM_REQ*16  packed addresses; requester i uses bits [16i+15:16i].
- avs_req_writedata  in  NUM_REQ*8  packed write bytes.
- avs_req_readdata  out  8  shared read byte; valid in requester's completion cycle.
- avs_req_waitrequest  out  NUM_REQ  per-requester waitrequest.
- avm_m0_read  out  1  downstream read.
- avm_m0_write  out  1  downstream write.
- avm_m0_address  out  16  downstream address.
- avm_m0_writedata  out  8  downstream write byte.
- avm_m0_readdata  in  8  downstream read byte.
- avm_m0_waitrequest  in  1  downstream busy.
- timeout_flag  out  1  sticky; set on any timeout.
- timeout_clear  in  1  clears timeout_flag.

Behaviour:
- Clock and reset: one clock, csi_clk. rsi_reset is asynchronous, active-high, and returns all state to IDLE.
- Reset values:
  - avm_m0_read/write = 0; avm_m0_address = 0; avm_m0_writedata = 0.
  - avs_req_readdata = 0; avs_req_waitrequest = all 1; timeout_flag = 0.
  - rr pointer = NUM_REQ-1, so requester 0 wins first.
- avs_req_waitrequest[i] = 0 only when state == DONE and grant == i; otherwise 1 (combinational from registered state/grant). Each completion is exactly one cycle of low waitrequest.
- States:
  - IDLE: avm strobes low.
    - Exit when any req (read|write) is pending and avm_m0_waitrequest == 0.
    - Round-robin pick: first pending index after the rr pointer, wrapping modulo NUM_REQ.
    - Latch grant, read/write, address and writedata into the avm_* registers; update rr pointer to grant; go to ISSUE.
    - If both read and write are asserted on one requester, treat it as a write.
  - ISSUE: avm strobe held high.
    - avm_m0_waitrequest == 1 -> BUSY (reset the timeout counter).
    - Else after ACCEPT_CYCLES cycles -> set timeout_flag and go to DONE with readdata = 8'hFF.
  - BUSY: strobe, address and data held stable.
    - avm_m0_waitrequest == 0 -> capture avm_m0_readdata into avs_req_readdata (writes also capture, value don't-care) and go to DONE.
    - Counter reaches TIMEOUT_CYCLES-1 -> set timeout_flag, avs_req_readdata = 8'hFF, go to DONE, and mark drain_needed.
  - DONE: one cycle.
    - Strobes drop to 0; granted requester sees waitrequest = 0.
    - Next state: DRAIN if drain_needed, else IDLE.
  - DRAIN: wait for avm_m0_waitrequest == 0, then go to IDLE; no new issue meanwhile.
- Latency: minimum requester-visible latency is downstream busy time + 3 cycles (IDLE latch, ISSUE, DONE).
- Fairness: the granted requester cannot win again while another is pending. A requester already pending when a grant is made is served within NUM_REQ transactions.
- Requester inputs are sampled only in IDLE; changes by a non-granted requester have no effect.
- timeout_clear and a timeout set in the same cycle: the set wins.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1), saturating, never wraps.
- NUM_REQ == 1: grant is constant 0 and the pointer logic degenerates; behaviour is otherwise unchanged.

Decomposition:
- Package eeprom_arb_pkg holds:
  - `typedef enum` ArbState {IDLE, ISSUE, BUSY, DONE, DRAIN};
  - localparam TIMEOUT_READDATA = 8'hFF;
  - function grantWidth(n) = max(1, $clog2(n)).
- Sub-module rr_arbiter (parameter NUM_REQ):
  - inputs: request vector, pointer, enable.
  - outputs: one-hot grant, encoded index, any_req.
  - Purely combinational priority rotate, reusable for the planned motion-config bus.

Test Plan:
- Single read: req1 reads 16'h0123; downstream model raises waitrequest 1 cycle after the strobe, holds it 50 cycles, returns 8'hA5 -> req1 waitrequest low for exactly 1 cycle with readdata 8'hA5; avm_m0_address stays 16'h0123 throughout.
- Round-robin: after reset, req0, req1 and req2 assert reads in the same cycle, and req0 re-requests immediately after completing -> grant order 0,1,2,0; no requester is served twice while another is pending.
- Write then read: req2 writes 8'h3C to 16'h0010, then req0 reads 16'h0010 -> avm_m0_write high with writedata 8'h3C held until completion, followed by a read returning the model's 8'h3C.
- Busy timeout: TIMEOUT_CYCLES = 100 and the model holds waitrequest high for 500 cycles -> completion at issue + ~102 cycles, readdata 8'hFF, timeout_flag = 1; the next request is not issued until the model drops waitrequest; timeout_clear resets the flag.
- Accept timeout: the model never raises waitrequest -> DONE after ACCEPT_CYCLES with readdata 8'hFF and timeout_flag set.
- Reset mid-BUSY: assert rsi_reset asynchronously during a transfer -> avm strobes drop immediately without waiting for a clock edge; all requester waitrequests go high; the first post-reset grant goes to the lowest pending index.

Source files
------------

// File: rtl/eeprom_arb_pkg.sv
// Shared types and constants for the EEPROM access arbiter.
package eeprom_arb_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, DONE, DRAIN} ArbState;

  localparam logic [7:0] TIMEOUT_READDATA = 8'hFF;

  function automatic int grantWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eeprom_access_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_arbiter
  import eeprom_arb_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int GW      = grantWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [GW-1:0]      grant_idx,
  output logic               any_req
);

  logic found;
  int   base;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    base      = int'(ptr);
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (enable && !found && req[i] && (i == (base + off) % NUM_REQ)) begin
          found       = 1'b1;
          grant_oh[i] = 1'b1;
          grant_idx   = GW'(i);
        end
      end
    end
  end

  assign any_req = enable && (|req);

endmodule

// File: rtl/eeprom_access_arbiter.sv
// Round-robin sharing of the I2C EEPROM byte port between NUM_REQ Avalon requesters,
// with accept and busy timeouts.
//   state | meaning
//   IDLE  | no transfer; arbitrate when downstream is free
//   ISSUE | strobe up, waiting for downstream waitrequest to rise
//   BUSY  | downstream working; strobe/address/data held
//   DONE  | one-cycle completion to the granted requester
//   DRAIN | after a busy timeout, wait for downstream to go idle
module eeprom_access_arbiter
  import eeprom_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int ACCEPT_CYCLES  = 4
) (
  input  logic                   csi_clk,
  input  logic                   rsi_reset,
  input  logic [NUM_REQ-1:0]     avs_req_read,
  input  logic [NUM_REQ-1:0]     avs_req_write,
  input  logic [NUM_REQ*16-1:0]  avs_req_address,
  input  logic [NUM_REQ*8-1:0]   avs_req_writedata,
  output logic [7:0]             avs_req_readdata,
  output logic [NUM_REQ-1:0]     avs_req_waitrequest,
  output logic                   avm_m0_read,
  output logic                   avm_m0_write,
  output logic [15:0]            avm_m0_address,
  output logic [7:0]             avm_m0_writedata,
  input  logic [7:0]             avm_m0_readdata,
  input  logic                   avm_m0_waitrequest,
  output logic                   timeout_flag,
  input  logic                   timeout_clear
);

  localparam int GW = grantWidth(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(ACCEPT_CYCLES + 1);

  ArbState       state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic          avm_read_q, avm_read_d;
  logic          avm_write_q, avm_write_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          flag_q, flag_d;
  logic          drain_q, drain_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;

  logic [NUM_REQ-1:0] pending, arb_oh;
  logic [GW-1:0]      arb_idx;
  logic               arb_any, arb_en, write_sel, timeout_set;

  assign pending   = avs_req_read | avs_req_write;
  assign arb_en    = (state_q == IDLE) && !avm_m0_waitrequest;
  assign write_sel = |(avs_req_write & arb_oh);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (pending),
    .ptr       (ptr_q),
    .enable    (arb_en),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    avm_read_d  = avm_read_q;
    avm_write_d = avm_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    drain_d     = drain_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    timeout_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d     = arb_idx;
          ptr_d       = arb_idx;
          // a requester driving both strobes is served as a write
          avm_write_d = write_sel;
          avm_read_d  = !write_sel;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_oh[i]) begin
              addr_d  = avs_req_address[16*i +: 16];
              wdata_d = avs_req_writedata[8*i +: 8];
            end
          end
          acc_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (avm_m0_waitrequest) begin
          cnt_d   = '0;
          state_d = BUSY;
        end else if (acc_q == AW'(ACCEPT_CYCLES - 1)) begin
          timeout_set = 1'b1;
          rdata_d     = TIMEOUT_READDATA;
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          state_d     = DONE;
        end else begin
          acc_d = acc_q + AW'(1);
        end
      end
      BUSY: begin
        if (!avm_m0_waitrequest) begin
          rdata_d     = avm_m0_readdata;
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          state_d     = DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout_set = 1'b1;
          rdata_d     = TIMEOUT_READDATA;
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          drain_d     = 1'b1;
          state_d     = DONE;
        end else if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = drain_q ? DRAIN : IDLE;
        drain_d = 1'b0;
      end
      DRAIN: begin
        if (!avm_m0_waitrequest) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    flag_d = flag_q;
    if (timeout_clear) flag_d = 1'b0;
    if (timeout_set)   flag_d = 1'b1;
  end

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= GW'(NUM_REQ - 1);
      avm_read_q  <= 1'b0;
      avm_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      flag_q      <= 1'b0;
      drain_q     <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      avm_read_q  <= avm_read_d;
      avm_write_q <= avm_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      flag_q      <= flag_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_wreq
    assign avs_req_waitrequest[gi] = !((state_q == DONE) && (grant_q == GW'(gi)));
  end

  assign avm_m0_read      = avm_read_q;
  assign avm_m0_write     = avm_write_q;
  assign avm_m0_address   = addr_q;
  assign avm_m0_writedata = wdata_q;
  assign avs_req_readdata = rdata_q;
  assign timeout_flag     = flag_q;

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// Randomized + directed bench for eeprom_access_arbiter against a transaction-level model.
module tb_eeprom_access_arbiter;

  localparam int NR = 3;
  localparam int TO = 100;
  localparam int AC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     rd, wr;
  logic [NR*16-1:0]  abus;
  logic [NR*8-1:0]   dbus;
  logic [7:0]        rdata_o;
  logic [NR-1:0]     wreq_o;
  logic              m_rd, m_wr;
  logic [15:0]       m_addr;
  logic [7:0]        m_wdata, m_rdata;
  logic              m_wait;
  logic              tflag, tclr;

  eeprom_access_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .ACCEPT_CYCLES(AC)) dut (
    .csi_clk             (clk),
    .rsi_reset           (rst),
    .avs_req_read        (rd),
    .avs_req_write       (wr),
    .avs_req_address     (abus),
    .avs_req_writedata   (dbus),
    .avs_req_readdata    (rdata_o),
    .avs_req_waitrequest (wreq_o),
    .avm_m0_read         (m_rd),
    .avm_m0_write        (m_wr),
    .avm_m0_address      (m_addr),
    .avm_m0_writedata    (m_wdata),
    .avm_m0_readdata     (m_rdata),
    .avm_m0_waitrequest  (m_wait),
    .timeout_flag        (tflag),
    .timeout_clear       (tclr)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;

  bit          act[NR], rwr[NR], rboth[NR];
  logic [15:0] raddr[NR];
  logic [7:0]  rdat[NR];

  logic [7:0]  ds_mem[65536];
  logic [7:0]  ref_mem[65536];

  int          ref_last;
  bit          ref_flag;
  bit          fl_valid, fl_wr, fl_to;
  int          fl_req, fl_due;
  logic [15:0] fl_addr;
  logic [7:0]  fl_wdata, fl_exp;

  int          ds_raise, ds_drop, ds_len_cfg;
  bit          ds_wr, ds_never_cfg, rand_mode;
  logic [15:0] ds_addr;
  logic [7:0]  ds_wdata;

  int          served[$];
  logic [7:0]  last_rdata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit any_act();
    bit a = 1'b0;
    for (int i = 0; i < NR; i++) a |= act[i];
    return a;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      rd[i]            = act[i] && (!rwr[i] || rboth[i]);
      wr[i]            = act[i] && rwr[i];
      abus[16*i +: 16] = raddr[i];
      dbus[8*i +: 8]   = rdat[i];
    end
  endtask

  task automatic post(input int i, input bit w, input bit both, input logic [15:0] a, input logic [7:0] d);
    act[i] = 1'b1; rwr[i] = w; rboth[i] = both; raddr[i] = a; rdat[i] = d;
    drive_reqs();
  endtask

  // One negedge: check outputs against the model, advance the downstream model, drive requesters.
  task automatic step();
    logic [NR-1:0] exp_w;
    bit due_now, never;
    int pred, len;
    @(negedge clk);
    cyc++;
    due_now = fl_valid && (cyc == fl_due);
    if (due_now && fl_to) ref_flag = 1'b1;
    else if (tclr)        ref_flag = 1'b0;
    check_val("flag", 32'(tflag), 32'(ref_flag));
    exp_w = '1;
    if (due_now) exp_w[fl_req] = 1'b0;
    check_val("wreq", 32'(wreq_o), 32'(exp_w));
    if (fl_valid && cyc < fl_due) begin
      check_val("hold_addr", 32'(m_addr), 32'(fl_addr));
      check_val("hold_strobe", 32'({m_wr, m_rd}), fl_wr ? 32'd2 : 32'd1);
      if (fl_wr) check_val("hold_wdata", 32'(m_wdata), 32'(fl_wdata));
    end
    if (due_now) begin
      check_val("done_strobe", 32'({m_wr, m_rd}), 32'd0);
      if (!fl_wr || fl_to) check_val("rdata", 32'(rdata_o), 32'(fl_exp));
      if (fl_wr && !fl_to) ref_mem[fl_addr] = fl_wdata;
      last_rdata  = rdata_o;
      act[fl_req] = 1'b0;
      served.push_back(fl_req);
      fl_valid    = 1'b0;
    end else if (!fl_valid && (m_rd || m_wr)) begin
      check_val("issue_gate", 32'(m_wait), 32'd0);
      pred = -1;
      for (int off = 1; off <= NR; off++)
        if (pred < 0 && act[(ref_last + off) % NR]) pred = (ref_last + off) % NR;
      if (pred < 0) begin
        check_val("issue_pending", 32'(any_act()), 32'd1);
      end else begin
        check_val("issue_addr", 32'(m_addr), 32'(raddr[pred]));
        check_val("issue_kind", 32'({m_wr, m_rd}), rwr[pred] ? 32'd2 : 32'd1);
        ref_last = pred;
        fl_valid = 1'b1; fl_req = pred; fl_addr = raddr[pred];
        fl_wr = rwr[pred]; fl_wdata = rdat[pred];
        never = rand_mode ? ($urandom_range(0, 7) == 0) : ds_never_cfg;
        len   = rand_mode ? int'($urandom_range(1, 8)) : ds_len_cfg;
        if (never) begin
          fl_due = cyc + AC; fl_to = 1'b1; fl_exp = 8'hFF;
          ds_raise = -1; ds_drop = -1;
        end else begin
          ds_raise = cyc + 1; ds_drop = cyc + len + 1;
          ds_wr = m_wr; ds_addr = m_addr; ds_wdata = m_wdata;
          if (len <= TO) begin
            fl_due = cyc + len + 2; fl_to = 1'b0; fl_exp = ref_mem[fl_addr];
          end else begin
            fl_due = cyc + TO + 2; fl_to = 1'b1; fl_exp = 8'hFF;
          end
        end
      end
    end
    if (cyc == ds_raise) m_wait = 1'b1;
    if (cyc == ds_drop) begin
      m_wait = 1'b0;
      if (ds_wr) ds_mem[ds_addr] = ds_wdata;
      else       m_rdata = ds_mem[ds_addr];
    end
    drive_reqs();
  endtask

  task automatic clear_model();
    fl_valid = 1'b0; ds_raise = -1; ds_drop = -1; m_wait = 1'b0;
    ref_last = NR - 1; ref_flag = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_issue(input int budget);
    int n = 0;
    while (!fl_valid && n < budget) begin step(); n++; end
    check_val("issued", 32'(fl_valid), 32'd1);
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((fl_valid || any_act()) && n < budget) begin step(); n++; end
    check_val("quiet", 32'({fl_valid, any_act()}), 32'd0);
  endtask

  initial begin
    int  order[4];
    bit  reposted;
    for (int a = 0; a < 65536; a++) begin
      ds_mem[a]  = 8'(a) ^ 8'h5A;
      ref_mem[a] = 8'(a) ^ 8'h5A;
    end
    ds_mem[16'h0123]  = 8'hA5;
    ref_mem[16'h0123] = 8'hA5;
    for (int i = 0; i < NR; i++) begin
      act[i] = 1'b0; rwr[i] = 1'b0; rboth[i] = 1'b0; raddr[i] = '0; rdat[i] = '0;
    end
    drive_reqs();
    m_rdata = '0; tclr = 1'b0; rand_mode = 1'b0; ds_never_cfg = 1'b0; ds_len_cfg = 2;
    rst = 1'b1;
    clear_model();
    step(); step();
    check_val("rst_read", 32'(m_rd), 32'd0);
    check_val("rst_write", 32'(m_wr), 32'd0);
    check_val("rst_addr", 32'(m_addr), 32'd0);
    check_val("rst_wdata", 32'(m_wdata), 32'd0);
    check_val("rst_rdata", 32'(rdata_o), 32'd0);
    check_val("rst_wreq", 32'(wreq_o), 32'(3'b111));
    check_val("rst_flag", 32'(tflag), 32'd0);
    rst = 1'b0;

    // single read with a 50-cycle busy downstream
    ds_len_cfg = 50;
    post(1, 1'b0, 1'b0, 16'h0123, 8'h00);
    wait_quiet(200);
    check_val("single_rdata", 32'(last_rdata), 32'hA5);

    // simultaneous requests, requester 0 re-requests at once
    do_reset();
    ds_len_cfg = 3;
    served.delete();
    post(0, 1'b0, 1'b0, 16'h0100, 8'h00);
    post(1, 1'b0, 1'b0, 16'h0101, 8'h00);
    post(2, 1'b0, 1'b0, 16'h0102, 8'h00);
    reposted = 1'b0;
    for (int n = 0; n < 100 && !reposted; n++) begin
      step();
      if (served.size() >= 1) begin
        post(0, 1'b0, 1'b0, 16'h0103, 8'h00);
        reposted = 1'b1;
      end
    end
    wait_quiet(200);
    order = '{0, 1, 2, 0};
    check_val("rr_count", 32'(served.size()), 32'd4);
    for (int j = 0; j < 4 && j < served.size(); j++) check_val("rr_order", served[j], order[j]);

    // write then read of the same byte
    ds_len_cfg = 5;
    post(2, 1'b1, 1'b0, 16'h0010, 8'h3C);
    wait_quiet(100);
    post(0, 1'b0, 1'b0, 16'h0010, 8'h00);
    wait_quiet(100);
    check_val("wr_then_rd", 32'(last_rdata), 32'h3C);

    // both strobes on one requester count as a write
    post(1, 1'b1, 1'b1, 16'h0400, 8'h77);
    wait_quiet(100);
    post(2, 1'b0, 1'b0, 16'h0400, 8'h00);
    wait_quiet(100);
    check_val("both_is_write", 32'(last_rdata), 32'h77);

    // busy timeout, drain, another requester waiting
    ds_len_cfg = 500;
    post(1, 1'b0, 1'b0, 16'h0200, 8'h00);
    wait_issue(20);
    ds_len_cfg = 3;
    post(2, 1'b0, 1'b0, 16'h0201, 8'h00);
    wait_quiet(1000);
    check_val("busy_to_flag", 32'(tflag), 32'd1);
    tclr = 1'b1; step(); tclr = 1'b0; step();
    check_val("flag_cleared", 32'(tflag), 32'd0);

    // accept timeout with clear held high: set wins in the same cycle
    ds_never_cfg = 1'b1;
    tclr = 1'b1;
    post(0, 1'b0, 1'b0, 16'h0300, 8'h00);
    wait_quiet(50);
    step();
    tclr = 1'b0;
    ds_never_cfg = 1'b0;
    step();

    // asynchronous reset during BUSY
    ds_len_cfg = 40;
    post(2, 1'b0, 1'b0, 16'h0500, 8'h00);
    wait_issue(20);
    post(1, 1'b0, 1'b0, 16'h0501, 8'h00);
    repeat (5) step();
    check_val("pre_rst_strobe", 32'(m_rd), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("async_rd", 32'(m_rd), 32'd0);
    check_val("async_wr", 32'(m_wr), 32'd0);
    check_val("async_wreq", 32'(wreq_o), 32'(3'b111));
    clear_model();
    served.delete();
    ds_len_cfg = 3;
    step(); step();
    rst = 1'b0;
    wait_quiet(100);
    check_val("post_rst_first", served.size() > 0 ? served[0] : -1, 1);

    // randomized traffic
    rand_mode = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      step();
      tclr = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!act[i] && $urandom_range(0, 3) == 0) begin
          post(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
               16'($urandom_range(0, 15)), 8'($urandom));
        end
      end
    end
    tclr = 1'b0;
    wait_quiet(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
